// File: rtl/dmem_pkg.sv
// Shared definitions for the DataMem arbiter: FSM encodings, memory geometry,
// requester ids and the byte-address legality rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_STROBE = 2'd2,
    ST_RESP   = 2'd3
  } dmem_state_e;

  localparam int unsigned DMEM_WORDS     = 128;
  localparam int unsigned DMEM_WORD_BITS = 7;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Word-aligned and inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned words);
    return (addr[1:0] == 2'b00) && (addr < 32'(words * 4));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker. The history bit remembers the last granted
// port so a tie goes to the other one.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o,
  output logic       grant_valid_o
);

  logic last_q, last_d;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == PORT1) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign grant_valid_o = |grant_o;
  assign last_d        = grant_valid_o ? grant_o[1] : last_q;

  // Reset to "port 1 granted last" so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= PORT1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serializes two valid/ready requesters onto the single-port DataMem and
// sequences MemRead / a clean one-cycle MemWrite pulse for each access.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output dmem_state_e dbg_state
);

  // Handshake: a request transfers in the cycle where reqN_valid and
  // reqN_ready are both 1; ready only rises in IDLE and never on both ports.
  dmem_state_e state_q;
  logic        wr_q, port_q;
  logic [31:0] addr_q, wdata_q;
  logic        mem_read_q, mem_write_q;
  logic [1:0]  rsp_valid_q, rsp_err_q;
  logic [31:0] rdata_q [2];

  logic [1:0]  req_vec, grant;
  logic        grant_valid, gnt_port, sel_write;
  logic [31:0] sel_addr, sel_wdata;

  assign req_vec = (state_q == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req_vec),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign gnt_port   = grant[1];
  assign sel_write  = gnt_port ? req1_write : req0_write;
  assign sel_addr   = gnt_port ? req1_addr  : req0_addr;
  assign sel_wdata  = gnt_port ? req1_wdata : req0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      port_q      <= PORT0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            port_q <= gnt_port;
            wr_q   <= sel_write;
            // Illegal requests leave the memory-side address/data untouched.
            if (addr_legal(sel_addr, MEM_WORDS)) begin
              addr_q     <= sel_addr;
              wdata_q    <= sel_wdata;
              mem_read_q <= ~sel_write;
              state_q    <= ST_ACCESS;
            end else begin
              rdata_q[gnt_port]     <= '0;
              rsp_valid_q[gnt_port] <= 1'b1;
              rsp_err_q[gnt_port]   <= 1'b1;
              state_q               <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (wr_q) begin
            mem_write_q <= 1'b1;
            state_q     <= ST_STROBE;
          end else begin
            rdata_q[port_q]     <= mem_rdata;
            rsp_valid_q[port_q] <= 1'b1;
            state_q             <= ST_RESP;
          end
        end
        ST_STROBE: begin
          rsp_valid_q[port_q] <= 1'b1;
          state_q             <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];
  assign rsp0_rdata = rdata_q[0];
  assign rsp1_rdata = rdata_q[1];
  assign dbg_state  = state_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the 128×32 single-port `DataMem` block. Two requesters share the memory: port 0 is the processor load/store path and port 1 is the debug/DMA loader. Each requester issues word-sized read or write requests over a valid/ready handshake. The block serializes them with round-robin arbitration and generates the `MemRead` level and a clean single-cycle `MemWrite` pulse. `DataMem` writes on the rising edge of `MemWrite`.

## Interface
Parameters:
- `MEM_WORDS`, 128: memory depth in words; legal byte addresses are 0 .. 4*MEM_WORDS-1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending on port 0 / 1.
- `req0_write` / `req1_write`  in  1  1 = write, 0 = read.
- `req0_addr` / `req1_addr`  in  32  byte address.
- `req0_wdata` / `req1_wdata`  in  32  write data.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle completion pulse.
- `rsp0_rdata` / `rsp1_rdata`  out  32  read data, held until the next response on that port.
- `rsp0_err` / `rsp1_err`  out  1  request was rejected; qualified by `rspN_valid`.
- `MemRead`  out  1  drives `DataMem.MemRead`.
- `MemWrite`  out  1  drives `DataMem.MemWrite`; all writes occur on its rising edge.
- `mem_addr`  out  32  drives `DataMem.addr`.
- `mem_wdata`  out  32  drives `DataMem.write_data`.
- `mem_rdata`  in  32  from `DataMem.read_data`.

## Operation
- FSM states: IDLE, ACCESS, STROBE, RESP.
- IDLE:
  - Pick one of the valid ports with the round-robin picker and assert its `reqN_ready` combinationally in the same cycle.
  - Latch `write`, `addr`, `wdata` and the port id.
  - If the address is legal, go to ACCESS; otherwise go to RESP with the error flag set.
- Legal address: `addr[1:0]==0` and `addr < 4*MEM_WORDS`. An illegal request never touches memory: `MemRead`/`MemWrite` stay 0, `rdata` is 0, `err` is 1.
- ACCESS:
  - `mem_addr` and `mem_wdata` are driven from the latches.
  - Read: `MemRead`=1; capture `mem_rdata` into the granted port's `rdata` register at the end of the cycle, then go to RESP.
  - Write: `MemWrite`=0 (address/data setup cycle), then go to STROBE.
- STROBE: `MemWrite`=1 for exactly one cycle; address and data remain stable; go to RESP.
- RESP: the granted port's `rspN_valid`=1 for one cycle, then return to IDLE. The next grant happens no earlier than that IDLE cycle.
- Round-robin: when both ports are valid, grant the port not granted last. With a single requester, grant it regardless of history. The history bit updates only on a grant.
- `mem_addr`/`mem_wdata` hold their last values outside an access. `MemRead`/`MemWrite` are 0 in every state except as stated above.
- `MemRead`, `MemWrite`, `rspN_valid` and `rspN_err` are registered (decoded from registered state bits); no glitches on `MemWrite`.

## Timing
- Reset values:
  - state IDLE;
  - `MemRead`, `MemWrite`, `reqN_ready`, `rspN_valid`, `rspN_err` all 0;
  - `rspN_rdata` 0; `mem_addr` 0; `mem_wdata` 0;
  - history set so port 0 wins the first tie.
- Latency from the accept cycle T (ready=1):
  - read: ACCESS at T+1, `rsp_valid` at T+2;
  - write: `MemWrite` high in T+2, `rsp_valid` at T+3;
  - illegal request: `rsp_valid` at T+1.
- Throughput: one request per 3 cycles for reads and 4 cycles for writes; the accept cycle is included.
- Requester holds `valid` and its fields stable until it sees `ready`. Fields are sampled only in the accept cycle.
- `ready` is never asserted outside IDLE. Both `ready` outputs are never 1 in the same cycle.
- Reset asserted mid-operation: `MemWrite` drops immediately, and a falling edge never writes. An in-flight request is discarded with no response. The requester must reissue it.

## Structure
- Shared package/include `dmem_pkg`:
  - state encodings;
  - `DMEM_WORDS`=128;
  - `DMEM_WORD_BITS`=7;
  - port-id constants.
- Sub-module `rr_arb2`: two-request round-robin picker with a registered history bit (clk/reset). Its outputs are the one-hot grant and `grant_valid`.
- `dmem_arbiter` contains the FSM, request latches, per-port response registers and address legality check. It instantiates `rr_arb2` once. `DataMem` is instantiated by the parent, not inside this block.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 0x10 at T: `MemWrite` rises at T+2, `rsp0_valid` at T+3. A port 0 read of 0x10 then returns 0xDEADBEEF at accept+2.
- Both ports valid every cycle with reads: grants alternate 0,1,0,1 starting with port 0. No `rsp1` while port 0 is in flight.
- Read from addr 0x1FC (last word) succeeds. Read from 0x200 and from 0x13 each give `rsp_err`=1 and `rdata`=0 one cycle after accept, with `MemRead` and `MemWrite` never asserted.
- Port 1 only, back-to-back writes to 0x0 and 0x4: each is accepted, then the next accept comes in the IDLE cycle after RESP (4-cycle cadence). Memory holds both values.
- Reset asserted during STROBE of a write to 0x20: `MemWrite` goes 0 asynchronously, no `rsp_valid` appears, and the pre-existing memory content at 0x20 is unchanged unless the rising edge already occurred. After release, all outputs are at reset values and port 0 wins the next tie.
